// File: rtl/dec_pkg.sv
// Shared constants and helpers for the SEC-DED decode controller.
// H rows are packed as row r = bits [32r+31:32r]; the top used row is overall parity.
package dec_pkg;

    localparam int MAX_CODEWORD_WIDTH = 32;
    localparam int MAX_INFO_WIDTH     = 26;
    localparam int MAX_PARITY_WIDTH   =
        MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int POS_W              = $clog2(MAX_CODEWORD_WIDTH);
    localparam int MULT_LAT           = 2;

    // (8,4): columns 9,A,C,D,B,E,F,8 for bits 0..7
    localparam logic [191:0] H_MATRIX_1 =
        192'h00000000_00000000_000000FF_0000006C_00000072_00000059;
    // (16,11): column j = 0x10 | j
    localparam logic [191:0] H_MATRIX_2 =
        192'h00000000_0000FFFF_0000FF00_0000F0F0_0000CCCC_0000AAAA;
    // (32,26): column j = 0x20 | j
    localparam logic [191:0] H_MATRIX_3 =
        192'hFFFFFFFF_FFFF0000_FF00FF00_F0F0F0F0_CCCCCCCC_AAAAAAAA;

    typedef enum logic [1:0] {
        STAT_CLEAN   = 2'b00,
        STAT_CORR    = 2'b01,
        STAT_UNCORR  = 2'b10,
        STAT_ILLEGAL = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        EVAL,
        SEARCH,
        DONE
    } state_e;

    function automatic logic [5:0] n_of(input logic [1:0] mode);
        unique case (mode)
            2'b00:   n_of = 6'd8;
            2'b01:   n_of = 6'd16;
            default: n_of = 6'd32;
        endcase
    endfunction

    function automatic logic [2:0] k_of(input logic [1:0] mode);
        unique case (mode)
            2'b00:   k_of = 3'd4;
            2'b01:   k_of = 3'd5;
            default: k_of = 3'd6;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input logic [1:0] mode);
        unique case (mode)
            2'b00:   mask_of = 32'h0000_00FF;
            2'b01:   mask_of = 32'h0000_FFFF;
            default: mask_of = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dec_col_sel.sv
// Returns column j of the H matrix selected by the work mode.
// Illegal mode yields an all-zero column.
module dec_col_sel
    import dec_pkg::*;
(
    input  logic [1:0]                  mode,
    input  logic [POS_W-1:0]            col,
    output logic [MAX_PARITY_WIDTH-1:0] h_col
);

    logic [191:0] h;
    logic [31:0]  row;

    always_comb begin
        h     = '0;
        row   = '0;
        h_col = '0;
        unique case (mode)
            2'b00:   h = H_MATRIX_1;
            2'b01:   h = H_MATRIX_2;
            2'b10:   h = H_MATRIX_3;
            default: h = '0;
        endcase
        for (int r = 0; r < MAX_PARITY_WIDTH; r++) begin
            row      = h[32*r +: 32];
            h_col[r] = row[col];
        end
    end

endmodule

// File: rtl/dec_ctrl.sv
// Sequencing controller for the shared syndrome multiplier.
// Accepts a codeword, waits for its syndrome, and corrects one bit by column search.
module dec_ctrl
    import dec_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic [MAX_CODEWORD_WIDTH-1:0] mult_data,
    output logic [1:0]                    mult_mode,
    input  logic [MAX_PARITY_WIDTH-1:0]   mult_syndrome,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [POS_W-1:0]              err_pos,
    output logic [1:0]                    status
);

    localparam int CW = MAX_CODEWORD_WIDTH;
    localparam int PW = MAX_PARITY_WIDTH;
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]       data_q, data_d;
    logic [1:0]          mode_q, mode_d;
    logic [PW-1:0]       syn_q, syn_d;
    logic [POS_W-1:0]    j_q, j_d;
    logic [CW-1:0]       dout_q, dout_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    status_e             stat_q, stat_d;

    logic [2:0]          k;
    logic [5:0]          n;
    logic [PW-1:0]       kmask;
    logic [PW-1:0]       syn_k;
    logic                p_bit;
    logic                s_nz;
    logic [PW-1:0]       h_col;

    dec_col_sel u_col_sel (
        .mode  (mode_q),
        .col   (j_q),
        .h_col (h_col)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign mult_data = data_q;
    assign mult_mode = mode_q;
    assign data_out  = dout_q;
    assign err_pos   = pos_q;
    assign status    = stat_q;

    // Syndrome view restricted to the K rows used by the latched mode
    assign k     = k_of(mode_q);
    assign n     = n_of(mode_q);
    assign kmask = PW'((7'd1 << k) - 7'd1);
    assign syn_k = syn_q & kmask;
    assign p_bit = syn_q[k - 3'd1];
    assign s_nz  = |(syn_q & (kmask >> 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        syn_d   = syn_q;
        j_d     = j_q;
        dout_d  = dout_q;
        pos_d   = pos_q;
        stat_d  = stat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d = data_in & mask_of(work_mod);
                    mode_d = work_mod;
                    if (work_mod == 2'b11) begin
                        dout_d  = data_in & mask_of(work_mod);
                        pos_d   = '0;
                        stat_d  = STAT_ILLEGAL;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(MULT_LAT);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    syn_d   = mult_syndrome;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                j_d = '0;
                if (!p_bit) begin
                    dout_d  = data_q;
                    pos_d   = '0;
                    stat_d  = s_nz ? STAT_UNCORR : STAT_CLEAN;
                    state_d = DONE;
                end else begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (syn_k == (h_col & kmask)) begin
                    dout_d  = data_q ^ (CW'(1) << j_q);
                    pos_d   = j_q;
                    stat_d  = STAT_CORR;
                    state_d = DONE;
                end else if ({1'b0, j_q} == n - 6'd1) begin
                    dout_d  = data_q;
                    pos_d   = '0;
                    stat_d  = STAT_UNCORR;
                    state_d = DONE;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= '0;
            syn_q   <= '0;
            j_q     <= '0;
            dout_q  <= '0;
            pos_q   <= '0;
            stat_q  <= STAT_CLEAN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            syn_q   <= syn_d;
            j_q     <= j_d;
            dout_q  <= dout_d;
            pos_q   <= pos_d;
            stat_q  <= stat_d;
        end
    end

endmodule

// File: tb/tb_dec_ctrl.sv
// Directed bench for dec_ctrl with a behavioural syndrome multiplier.
// Latencies are counted in clock edges after the accept edge.
module tb_dec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  work_mod;
    logic [31:0] mult_data;
    logic [1:0]  mult_mode;
    logic [5:0]  mult_syndrome = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [4:0]  err_pos;
    logic [1:0]  status;

    int checks = 0;
    int fails  = 0;

    dec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .work_mod      (work_mod),
        .mult_data     (mult_data),
        .mult_mode     (mult_mode),
        .mult_syndrome (mult_syndrome),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .err_pos       (err_pos),
        .status        (status)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] hcol(input logic [1:0] m, input int j);
        logic [31:0] tab;
        tab = 32'h8FEBDCA9;
        hcol = '0;
        case (m)
            2'b00: if (j < 8) hcol = {2'b00, tab[4*j +: 4]};
            2'b01: if (j < 16) hcol = 6'h10 | 6'(j);
            2'b10: hcol = 6'h20 | 6'(j);
            default: hcol = '0;
        endcase
    endfunction

    function automatic logic [5:0] syn_model(input logic [31:0] d,
                                             input logic [1:0] m);
        syn_model = '0;
        for (int j = 0; j < 32; j++)
            if (d[j]) syn_model = syn_model ^ hcol(m, j);
    endfunction

    function automatic logic [31:0] msk(input logic [1:0] m);
        case (m)
            2'b00:   msk = 32'h0000_00FF;
            2'b01:   msk = 32'h0000_FFFF;
            default: msk = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Multiplier stand-in: one register stage, valid before the capture edge
    always @(posedge clk) mult_syndrome <= syn_model(mult_data, mult_mode);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] d,
                       input logic [1:0] m, input logic [1:0] es,
                       input logic [31:0] ed, input logic [4:0] ep,
                       input int el);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        data_in  = d;
        work_mod = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".mult_data"}, mult_data, d & msk(m));
        chk({tag, ".mult_mode"}, 32'(mult_mode), 32'(m));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(el));
        chk({tag, ".status"}, 32'(status), 32'(es));
        chk({tag, ".data_out"}, data_out, ed);
        chk({tag, ".err_pos"}, 32'(err_pos), 32'(ep));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        work_mod  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.data_out", data_out, 32'd0);
        chk("rst.status", 32'(status), 32'd0);
        chk("rst.mult_data", mult_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", 32'(in_ready), 32'd1);

        run("clean8", 32'h0000_00FF, 2'b00, 2'b00, 32'hFF, 5'd0, 3);
        release_out("clean8");
        run("single8", 32'h0000_00EF, 2'b00, 2'b01, 32'hFF, 5'd4, 8);
        release_out("single8");
        run("double8", 32'h0000_00FC, 2'b00, 2'b10, 32'hFC, 5'd0, 3);
        release_out("double8");
        run("masked8", 32'hABCD_12EF, 2'b00, 2'b01, 32'hFF, 5'd4, 8);
        release_out("masked8");
        run("triple8", 32'h0000_00F8, 2'b00, 2'b01, 32'hB8, 5'd6, 10);
        release_out("triple8");
        run("single32", 32'h8000_0000, 2'b10, 2'b01, 32'h0, 5'd31, 35);
        release_out("single32");
        run("single16", 32'h0000_8000, 2'b01, 2'b01, 32'h0, 5'd15, 19);
        release_out("single16");
        run("clean16", 32'hFFFF_FFFF, 2'b01, 2'b00, 32'hFFFF, 5'd0, 3);
        release_out("clean16");
        run("double32", 32'h0000_0003, 2'b10, 2'b10, 32'h3, 5'd0, 3);
        release_out("double32");

        run("illegal", 32'h1234_5678, 2'b11, 2'b11, 32'h1234_5678,
            5'd0, 0);
        in_valid = 1'b1;
        data_in  = 32'h0000_00FF;
        work_mod = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.status", 32'(status), 32'd3);
            chk("hold.data_out", data_out, 32'h1234_5678);
        end
        in_valid = 1'b0;
        release_out("illegal");

        @(negedge clk);
        data_in  = 32'h0000_00EF;
        work_mod = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("search.out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        chk("midrst.mult_data", mult_data, 32'd0);
        chk("midrst.status", 32'(status), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.in_ready_after", 32'(in_ready), 32'd1);
        run("post_rst", 32'h0000_00FF, 2'b00, 2'b00, 32'hFF, 5'd0, 3);
        release_out("post_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
